// File: rtl/cache_nway_control.sv
// ---------------------------------------------------------------------------
// cache_nway_control
//
// Control unit for a WAYS-way set-associative cache. Runs the request FSM
// (IDLE -> CHECK -> [WRITEBACK ->] FILL -> CHECK -> IDLE), chooses the
// victim on a miss, keeps one tree-PLRU entry per set, and drives every
// datapath mux select and array write enable.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   mem_read      CPU read request, held until mem_resp
//   mem_write     CPU write request, held until mem_resp (wins over read)
//   set_idx       set index of the current request
//   hit           per-way tag match, already qualified by valid
//   valid, dirty  valid / dirty bits of the indexed set
//   pmem_resp     physical memory transfer complete
//   mem_resp      CPU request complete (one cycle)
//   pmem_read     line fill request
//   pmem_write    line writeback request
//   data_in_sel   data array write source: 0 = CPU, 1 = physical memory
//   data_out_way  way whose data is returned to the CPU
//   mem_addr_sel  MSB=1: CPU address; MSB=0: victim tag address, low bits = way
//   data_we       data array write enable, one-hot
//   load_tag      tag/valid load, one-hot
//   set_dirty     dirty := 1, one-hot
//   clr_dirty     dirty := 0, one-hot
//
// Handshakes
//   CPU side: a request (mem_read/mem_write) is held by the CPU until the
//   cycle in which mem_resp is high; mem_resp is high for exactly one cycle
//   and the request is considered consumed on the clock edge ending it.
//   Memory side: pmem_read/pmem_write stay high until the cycle in which
//   pmem_resp is high; the transfer completes on the edge ending that cycle.
//   pmem_resp seen in any other state is ignored.
//
// Tree PLRU
//   WAYS-1 bits per set in heap order (node i has children 2i+1, 2i+2,
//   leaves are ways 0..WAYS-1 left to right). A 0 bit means the victim
//   lies in the left subtree. An access to way w makes every node on w's
//   path point away from w.
// ---------------------------------------------------------------------------
module cache_nway_control #(
  parameter int WAYS    = 4,
  parameter int S_INDEX = 3,
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [S_INDEX-1:0] set_idx,
  input  logic [WAYS-1:0]    hit,
  input  logic [WAYS-1:0]    valid,
  input  logic [WAYS-1:0]    dirty,
  input  logic               pmem_resp,
  output logic               mem_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               data_in_sel,
  output logic [WAY_W-1:0]   data_out_way,
  output logic [WAY_W:0]     mem_addr_sel,
  output logic [WAYS-1:0]    data_we,
  output logic [WAYS-1:0]    load_tag,
  output logic [WAYS-1:0]    set_dirty,
  output logic [WAYS-1:0]    clr_dirty
);

  localparam int SETS = 2 ** S_INDEX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  // state is the FSM observation point for checkers bound to this block.
  state_t state;
  state_t state_nxt;

  logic [WAYS-2:0]  plru_q [SETS];
  logic [WAY_W-1:0] victim_q;
  logic [WAY_W-1:0] victim_nxt;

  logic [WAYS-2:0]  plru_cur;
  logic [WAYS-2:0]  plru_upd;
  logic             plru_we;

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             inv_any;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] victim_sel;
  logic             victim_wb;
  logic [WAYS-1:0]  hit_oh;
  logic [WAYS-1:0]  victim_oh;

  assign plru_cur = plru_q[set_idx];
  assign hit_any  = |hit;
  assign inv_any  = ~&valid;

  // Lowest-index hit wins; more than one hit bit is illegal anyway.
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit[w]) hit_way = WAY_W'(w);
    end
  end

  // Lowest-index invalid way is always preferred over the PLRU choice.
  always_comb begin
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) inv_way = WAY_W'(w);
    end
  end

  // Walk the tree from the root following the stored bits; each level
  // contributes one bit of the victim way index, MSB first.
  always_comb begin
    int  node;
    logic b;
    node     = 0;
    b        = 1'b0;
    plru_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) b = plru_cur[n];
      end
      plru_way[WAY_W-1-l] = b;
      node = 2 * node + (b ? 2 : 1);
    end
  end

  // Walk the path of the hit way and point every node on it away from it.
  always_comb begin
    int  node;
    logic dir;
    node     = 0;
    dir      = 1'b0;
    plru_upd = plru_cur;
    for (int l = 0; l < WAY_W; l++) begin
      dir = hit_way[WAY_W-1-l];
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) plru_upd[n] = ~dir;
      end
      node = 2 * node + (dir ? 2 : 1);
    end
  end

  assign victim_sel = inv_any ? inv_way : plru_way;
  // An invalid victim never needs a writeback, even if its dirty bit is stale.
  assign victim_wb  = valid[victim_sel] & dirty[victim_sel];

  assign hit_oh    = {{(WAYS-1){1'b0}}, 1'b1} << hit_way;
  assign victim_oh = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      state    <= state_nxt;
      victim_q <= victim_nxt;
      if (plru_we) plru_q[set_idx] <= plru_upd;
    end
  end

  always_comb begin
    state_nxt    = state;
    victim_nxt   = victim_q;
    plru_we      = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    data_in_sel  = 1'b0;
    data_out_way = '0;
    mem_addr_sel = {1'b1, {WAY_W{1'b0}}};
    data_we      = '0;
    load_tag     = '0;
    set_dirty    = '0;
    clr_dirty    = '0;

    case (state)
      IDLE: begin
        if (mem_read || mem_write) state_nxt = CHECK;
      end

      CHECK: begin
        if (hit_any) begin
          mem_resp     = 1'b1;
          data_out_way = hit_way;
          plru_we      = 1'b1;
          // Read+write together is treated as a write.
          if (mem_write) begin
            data_we   = hit_oh;
            set_dirty = hit_oh;
          end
          state_nxt = IDLE;
        end else begin
          victim_nxt = victim_sel;
          state_nxt  = victim_wb ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        pmem_write   = 1'b1;
        mem_addr_sel = {1'b0, victim_q};
        if (pmem_resp) state_nxt = FILL;
      end

      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_in_sel = 1'b1;
          data_we     = victim_oh;
          load_tag    = victim_oh;
          clr_dirty   = victim_oh;
          state_nxt   = CHECK;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
